// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder/subtractor.
// Holds the sequencer state encoding and the default datapath width.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fulladder.sv
// Single-bit full-adder cell.
// Ports: a, b, ci in; s (sum), co (carry out) out.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one result bit per clock through one full adder.
// Ports: clk, reset (async high), start, sub, a, b, cin in;
//        busy, done, sum, cout, overflow, zero out (all registered state).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic             fa_s;
    logic             fa_co;
    logic             last;
    logic [WIDTH-1:0] sum_nxt;

    assign last    = (cnt == CNT_W'(WIDTH - 1));
    assign sum_nxt = {fa_s, sum[WIDTH-1:1]};

    fullAdder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result flags only move on the final RUN edge, so they stay
    // stable through DONE and IDLE until the next operation ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub | cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum   <= sum_nxt;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        // carry holds the carry into the MSB here
                        overflow <= carry ^ fa_co;
                        cout     <= fa_co;
                        zero     <= (sum_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=64.
// Drivers push model results; per-DUT monitors pop and compare on done.
module tb_serial_adder;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    logic       rst8, start8, sub8, cin8;
    logic [7:0] a8, b8, sum8;
    logic       busy8, done8, cout8, ovf8, zero8;

    logic        rst64, start64, sub64, cin64;
    logic [63:0] a64, b64, sum64;
    logic        busy64, done64, cout64, ovf64, zero64;

    exp_t q8[$];
    exp_t q64[$];
    exp_t last8, last64, e8, e64;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .reset(rst8), .start(start8), .sub(sub8),
        .a(a8), .b(b8), .cin(cin8), .busy(busy8), .done(done8),
        .sum(sum8), .cout(cout8), .overflow(ovf8), .zero(zero8)
    );

    serial_adder #(.WIDTH(64)) u64 (
        .clk(clk), .reset(rst64), .start(start64), .sub(sub64),
        .a(a64), .b(b64), .cin(cin64), .busy(busy64), .done(done64),
        .sum(sum64), .cout(cout64), .overflow(ovf64), .zero(zero64)
    );

    // Plain integer arithmetic; overflow from operand/result signs.
    function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b,
                                   logic sub, logic cin, int t);
        exp_t r;
        logic [64:0] m, full;
        logic [63:0] am, bm;
        m = (65'd1 << w) - 65'd1;
        am = a & m[63:0];
        bm = (sub ? ~b : b) & m[63:0];
        full = {1'b0, am} + {1'b0, bm} + {64'd0, (sub ? 1'b1 : cin)};
        r.sum = full[63:0] & m[63:0];
        r.cout = full[w];
        r.ovf = (am[w-1] == bm[w-1]) && (r.sum[w-1] != am[w-1]);
        r.zero = (r.sum == 64'd0);
        r.t = t;
        return r;
    endfunction

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst8 && done8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done8: unexpected done, got 1 expected 0");
            end else begin
                e8 = q8.pop_front();
                chk("sum8", {56'd0, sum8}, e8.sum);
                chk("cout8", {63'd0, cout8}, {63'd0, e8.cout});
                chk("ovf8", {63'd0, ovf8}, {63'd0, e8.ovf});
                chk("zero8", {63'd0, zero8}, {63'd0, e8.zero});
                chk("lat8", 64'(cyc - e8.t), 64'd8);
                last8 = e8;
            end
        end else if (!rst8 && !busy8) begin
            chk("hold_sum8", {56'd0, sum8}, last8.sum);
            chk("hold_zero8", {63'd0, zero8}, {63'd0, last8.zero});
        end
    end

    always @(negedge clk) begin
        if (!rst64 && done64) begin
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done64: unexpected done, got 1 expected 0");
            end else begin
                e64 = q64.pop_front();
                chk("sum64", sum64, e64.sum);
                chk("cout64", {63'd0, cout64}, {63'd0, e64.cout});
                chk("ovf64", {63'd0, ovf64}, {63'd0, e64.ovf});
                chk("zero64", {63'd0, zero64}, {63'd0, e64.zero});
                chk("lat64", 64'(cyc - e64.t), 64'd64);
                last64 = e64;
            end
        end else if (!rst64 && !busy64) begin
            chk("hold_sum64", sum64, last64.sum);
        end
    end

    task automatic wait_idle8();
        int n = 0;
        @(negedge clk);
        while (busy8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy8) begin
            checks++;
            errors++;
            $display("FAIL idle8: busy got 1 expected 0");
        end
    endtask

    task automatic issue8(logic [7:0] a, logic [7:0] b, logic s, logic c);
        wait_idle8();
        a8 = a; b8 = b; sub8 = s; cin8 = c; start8 = 1'b1;
        q8.push_back(model(8, {56'd0, a}, {56'd0, b}, s, c, cyc + 1));
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue64(logic [63:0] a, logic [63:0] b, logic s, logic c);
        int n = 0;
        @(negedge clk);
        while (busy64 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy64) begin
            checks++;
            errors++;
            $display("FAIL idle64: busy got 1 expected 0");
        end
        a64 = a; b64 = b; sub64 = s; cin64 = c; start64 = 1'b1;
        q64.push_back(model(64, a, b, s, c, cyc + 1));
        @(negedge clk);
        start64 = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain8", 64'(q8.size()), 64'd0);
    endtask

    task automatic drain64();
        int n = 0;
        while (q64.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain64", 64'(q64.size()), 64'd0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        last8 = '{default: 0};
        last64 = '{default: 0};
        rst8 = 1'b1; start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0;
        a8 = 8'd0; b8 = 8'd0;
        rst64 = 1'b1; start64 = 1'b0; sub64 = 1'b0; cin64 = 1'b0;
        a64 = 64'd0; b64 = 64'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy8", {63'd0, busy8}, 64'd0);
        chk("rst_done8", {63'd0, done8}, 64'd0);
        chk("rst_sum8", {56'd0, sum8}, 64'd0);
        chk("rst_flags8", {61'd0, cout8, ovf8, zero8}, 64'd0);
        chk("rst_busy64", {63'd0, busy64}, 64'd0);
        chk("rst_sum64", sum64, 64'd0);
        rst8 = 1'b0;
        rst64 = 1'b0;

        fork
            begin
                issue8(8'h3C, 8'h05, 1'b0, 1'b0);
                issue8(8'h7F, 8'h01, 1'b0, 1'b0);
                issue8(8'hFF, 8'h01, 1'b0, 1'b0);
                issue8(8'h10, 8'h20, 1'b1, 1'b0);
                issue8(8'h80, 8'h01, 1'b1, 1'b1);
                issue8(8'hFF, 8'h01, 1'b0, 1'b1);
                issue8(8'hFF, 8'h01, 1'b0, 1'b0);
                drain8();

                // start held high: only values at IDLE edges count
                begin
                    int nxt;
                    int acc = 0;
                    wait_idle8();
                    nxt = cyc + 1;
                    start8 = 1'b1;
                    while (acc < 5) begin
                        a8 = 8'($urandom);
                        b8 = 8'($urandom);
                        sub8 = 1'($urandom);
                        cin8 = 1'($urandom);
                        if (cyc + 1 == nxt) begin
                            q8.push_back(model(8, {56'd0, a8}, {56'd0, b8},
                                               sub8, cin8, nxt));
                            nxt += 10;
                            acc++;
                        end
                        @(negedge clk);
                    end
                    start8 = 1'b0;
                end
                drain8();

                // reset three cycles into RUN
                issue8(8'hFF, 8'h01, 1'b0, 1'b0);
                drain8();
                issue8(8'h55, 8'h55, 1'b0, 1'b0);
                @(negedge clk);
                @(negedge clk);
                last8 = '{default: 0};
                void'(q8.pop_back());
                rst8 = 1'b1;
                #1;
                chk("arst_busy8", {63'd0, busy8}, 64'd0);
                chk("arst_done8", {63'd0, done8}, 64'd0);
                chk("arst_sum8", {56'd0, sum8}, 64'd0);
                chk("arst_cout8", {63'd0, cout8}, 64'd0);
                chk("arst_ovf8", {63'd0, ovf8}, 64'd0);
                chk("arst_zero8", {63'd0, zero8}, 64'd0);
                @(negedge clk);
                @(negedge clk);
                rst8 = 1'b0;
                repeat (12) @(negedge clk);
                issue8(8'hA5, 8'h3C, 1'b0, 1'b1);
                drain8();
            end
            begin
                issue64(64'd5, 64'd7, 1'b1, 1'b0);
                issue64(64'd7, 64'd5, 1'b1, 1'b0);
                issue64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
                issue64(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0);
                for (int i = 0; i < 1000; i++) begin
                    issue64({$urandom, $urandom}, {$urandom, $urandom},
                            1'($urandom), 1'($urandom));
                end
                drain64();
            end
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
